// File: rtl/rank_order_encoder_v2.sv
// Rank-order / threshold AER encoder: scans a stored image and streams pixel
// indices through a small FIFO onto a 4-phase AER request/acknowledge link.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for NEW_IMAGE; BUSY low
// FINDMAX | one pass to find the brightest pixel (rank mode only)
// SCAN    | one pass per level; matching indices pushed into the FIFO
// DRAIN   | scanning finished, waiting for FIFO and AER link to go quiet
// ABORT   | FIFO flushed, letting the in-flight handshake finish
module rank_order_encoder_v2 #(
    parameter int IMAGE_SIZE = 784,
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_BITS  = $clog2(IMAGE_SIZE),
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_BITS   = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE,
    input  logic                             NEW_IMAGE,
    input  logic                             MODE,
    input  logic [PIXEL_BITS-1:0]            MIN_LEVEL,
    input  logic [CNT_BITS-1:0]              MAX_EVENTS,
    input  logic                             INFERENCE_DONE,
    output logic                             BUSY,
    output logic                             IMAGE_ENCODED,
    output logic [CNT_BITS-1:0]              EVENT_COUNT,
    output logic [ADDR_BITS-1:0]             AERIN_ADDR,
    output logic                             AERIN_REQ,
    input  logic                             AERIN_ACK
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW      = PTR_BITS + 1;

    localparam logic [ADDR_BITS-1:0] LAST_IDX      = ADDR_BITS'(IMAGE_SIZE - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX       = CNT_BITS'(IMAGE_SIZE);
    localparam logic [FCW-1:0]       FIFO_FULL_CNT = FCW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FINDMAX,
        S_SCAN,
        S_DRAIN,
        S_ABORT
    } state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_REQ,
        A_ACK_LOW
    } aer_t;

    state_t                 state;
    aer_t                   aer_st;

    logic                   mode_q;
    logic [PIXEL_BITS-1:0]  min_q;
    logic [CNT_BITS-1:0]    max_ev_q;
    logic [PIXEL_BITS-1:0]  level;
    logic [PIXEL_BITS-1:0]  next_lvl;
    logic                   next_valid;
    logic [PIXEL_BITS-1:0]  max_acc;
    logic [ADDR_BITS-1:0]   idx;
    logic [CNT_BITS-1:0]    pushed_cnt;
    logic                   busy_q;
    logic                   encoded_q;
    logic [CNT_BITS-1:0]    event_cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   req_q;

    logic [ADDR_BITS-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr;
    logic [PTR_BITS-1:0]    rd_ptr;
    logic [FCW-1:0]         fifo_cnt;

    logic [PIXEL_BITS-1:0]  pixels [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0]  pix;
    logic [PIXEL_BITS-1:0]  max_c;
    logic [PIXEL_BITS-1:0]  next_c;
    logic                   next_valid_c;
    logic                   lower;
    logic                   hit;
    logic                   start;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   drain_done;
    logic                   abort_now;
    logic                   scan_go;
    logic                   push;
    logic                   pop;
    logic                   cap_hit;
    logic [CNT_BITS-1:0]    push_inc;

    for (genvar g = 0; g < IMAGE_SIZE; g++) begin : g_pix
        assign pixels[g] = IMAGE[g*PIXEL_BITS +: PIXEL_BITS];
    end

    assign pix = pixels[idx];

    assign start      = (state == S_IDLE) && NEW_IMAGE;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign drain_done = (state == S_DRAIN) && fifo_empty && (aer_st == A_IDLE);

    // Completion beats abort when both land on the same DRAIN cycle.
    assign abort_now  = INFERENCE_DONE && !drain_done &&
                        ((state == S_FINDMAX) || (state == S_SCAN) || (state == S_DRAIN));

    assign scan_go    = (state == S_SCAN) && !fifo_full && !abort_now;
    assign hit        = mode_q ? (pix >= level) : (pix == level);
    assign push       = scan_go && hit;
    assign pop        = (aer_st == A_IDLE) && !fifo_empty && !abort_now && (state != S_ABORT);

    assign push_inc   = (pushed_cnt == CNT_MAX) ? CNT_MAX : pushed_cnt + 1'b1;
    assign cap_hit    = push && (max_ev_q != '0) && (push_inc == max_ev_q);

    assign max_c        = (pix > max_acc) ? pix : max_acc;
    assign lower        = !mode_q && (pix < level) && (!next_valid || (pix > next_lvl));
    assign next_c       = lower ? pix : next_lvl;
    assign next_valid_c = next_valid || lower;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            min_q      <= '0;
            max_ev_q   <= '0;
            level      <= '0;
            next_lvl   <= '0;
            next_valid <= 1'b0;
            max_acc    <= '0;
            idx        <= '0;
            pushed_cnt <= '0;
            busy_q     <= 1'b0;
            encoded_q  <= 1'b0;
        end else begin
            encoded_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (NEW_IMAGE) begin
                        mode_q     <= MODE;
                        min_q      <= MIN_LEVEL;
                        max_ev_q   <= MAX_EVENTS;
                        idx        <= '0;
                        max_acc    <= '0;
                        next_lvl   <= '0;
                        next_valid <= 1'b0;
                        pushed_cnt <= '0;
                        busy_q     <= 1'b1;
                        if (MODE) begin
                            level <= MIN_LEVEL;
                            state <= S_SCAN;
                        end else begin
                            state <= S_FINDMAX;
                        end
                    end
                end

                S_FINDMAX: begin
                    if (abort_now) begin
                        state <= S_ABORT;
                    end else begin
                        max_acc <= max_c;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (max_c < min_q) begin
                                state <= S_DRAIN;
                            end else begin
                                level <= max_c;
                                state <= S_SCAN;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                S_SCAN: begin
                    if (abort_now) begin
                        state <= S_ABORT;
                    end else if (scan_go) begin
                        if (push) begin
                            pushed_cnt <= push_inc;
                        end
                        if (cap_hit) begin
                            state <= S_DRAIN;
                        end else if (idx == LAST_IDX) begin
                            idx        <= '0;
                            next_valid <= 1'b0;
                            // A level below the floor (or none at all) ends the image.
                            if (mode_q || !next_valid_c || (next_c < min_q)) begin
                                state <= S_DRAIN;
                            end else begin
                                level <= next_c;
                            end
                        end else begin
                            idx        <= idx + 1'b1;
                            next_lvl   <= next_c;
                            next_valid <= next_valid_c;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_done) begin
                        encoded_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end else if (abort_now) begin
                        state <= S_ABORT;
                    end
                end

                S_ABORT: begin
                    if (aer_st == A_IDLE) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Event FIFO; an abort empties it in one cycle.
    always_ff @(posedge CLK) begin
        if (!RST || abort_now) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            aer_st    <= A_IDLE;
            addr_q    <= '0;
            req_q     <= 1'b0;
            event_cnt <= '0;
        end else begin
            if (start) begin
                event_cnt <= '0;
            end
            case (aer_st)
                A_IDLE: begin
                    if (pop) begin
                        addr_q <= fifo_mem[rd_ptr];
                        req_q  <= 1'b1;
                        aer_st <= A_REQ;
                    end
                end

                A_REQ: begin
                    if (AERIN_ACK) begin
                        req_q  <= 1'b0;
                        aer_st <= A_ACK_LOW;
                        if (event_cnt != CNT_MAX) begin
                            event_cnt <= event_cnt + 1'b1;
                        end
                    end
                end

                A_ACK_LOW: begin
                    if (!AERIN_ACK) begin
                        aer_st <= A_IDLE;
                    end
                end

                default: aer_st <= A_IDLE;
            endcase
        end
    end

    assign BUSY          = busy_q;
    assign IMAGE_ENCODED = encoded_q;
    assign EVENT_COUNT   = event_cnt;
    assign AERIN_ADDR    = addr_q;
    assign AERIN_REQ     = req_q;

endmodule

// File: tb/tb_rank_order_encoder_v2.sv
// Directed bench for rank_order_encoder_v2 on an 8-pixel image with a 2-entry FIFO.
module tb_rank_order_encoder_v2;

    localparam int N  = 8;
    localparam int PB = 8;
    localparam int AB = 3;
    localparam int CB = 4;

    logic              clk;
    logic              rst;
    logic [N*PB-1:0]   image;
    logic              new_image;
    logic              mode;
    logic [PB-1:0]     min_level;
    logic [CB-1:0]     max_events;
    logic              inference_done;
    logic              busy;
    logic              image_encoded;
    logic [CB-1:0]     event_count;
    logic [AB-1:0]     aer_addr;
    logic              aer_req;
    logic              aer_ack;

    int checks   = 0;
    int failures = 0;
    int ack_delay = 1;
    int ack_cyc   = 0;
    int enc_cnt   = 0;
    int unstable  = 0;
    int last_wait = 0;
    int addr_q[$];
    int exp_q[$];
    logic          req_prev  = 1'b0;
    logic [AB-1:0] addr_prev = '0;

    // pixels {3,7,7,0,5,3,9,1}, pixel 0 in the low byte
    localparam logic [N*PB-1:0] IMG_A = 64'h01_09_03_05_00_07_07_03;

    rank_order_encoder_v2 #(
        .IMAGE_SIZE (N),
        .PIXEL_BITS (PB),
        .ADDR_BITS  (AB),
        .FIFO_DEPTH (2),
        .CNT_BITS   (CB)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .IMAGE          (image),
        .NEW_IMAGE      (new_image),
        .MODE           (mode),
        .MIN_LEVEL      (min_level),
        .MAX_EVENTS     (max_events),
        .INFERENCE_DONE (inference_done),
        .BUSY           (busy),
        .IMAGE_ENCODED  (image_encoded),
        .EVENT_COUNT    (event_count),
        .AERIN_ADDR     (aer_addr),
        .AERIN_REQ      (aer_req),
        .AERIN_ACK      (aer_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Receiver: raise ACK ack_delay samples after REQ, drop it once REQ falls.
    initial begin
        aer_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!aer_req) begin
                ack_cyc = 0;
                if (aer_ack) aer_ack = 1'b0;
            end else if (!aer_ack) begin
                ack_cyc++;
                if (ack_cyc >= ack_delay) aer_ack = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (aer_req && !req_prev) addr_q.push_back(int'(aer_addr));
            if (aer_req && req_prev && (aer_addr != addr_prev)) unstable++;
            if (image_encoded) enc_cnt++;
            req_prev  = aer_req;
            addr_prev = aer_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        last_wait = n;
        chk({tag, " idle-within-budget"}, 32'(busy), 32'd0);
    endtask

    task automatic check_order(input string tag);
        chk({tag, " event-total"}, 32'(addr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [31:0] obs;
            obs = (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF_FFFF;
            chk($sformatf("%s addr[%0d]", tag, i), obs, 32'(exp_q[i]));
        end
    endtask

    task automatic start_image(input logic [N*PB-1:0] img, input logic md,
                               input logic [PB-1:0] lvl, input logic [CB-1:0] cap);
        image      = img;
        mode       = md;
        min_level  = lvl;
        max_events = cap;
        addr_q.delete();
        enc_cnt    = 0;
        unstable   = 0;
        new_image  = 1'b1;
        tick();
        new_image  = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        image          = '0;
        new_image      = 1'b0;
        mode           = 1'b0;
        min_level      = '0;
        max_events     = '0;
        inference_done = 1'b0;

        repeat (3) tick();
        chk("reset busy",  32'(busy),          32'd0);
        chk("reset enc",   32'(image_encoded), 32'd0);
        chk("reset count", 32'(event_count),   32'd0);
        chk("reset req",   32'(aer_req),       32'd0);
        chk("reset addr",  32'(aer_addr),      32'd0);
        rst = 1'b1;
        tick();

        // Rank order, no floor, no cap.
        ack_delay = 1;
        start_image(IMG_A, 1'b0, 8'd0, 4'd0);
        chk("t1 busy after start", 32'(busy), 32'd1);
        wait_idle("t1", 1000);
        repeat (3) tick();
        exp_q = '{6, 1, 2, 4, 0, 5, 7, 3};
        check_order("t1");
        chk("t1 event_count", 32'(event_count), 32'd8);
        chk("t1 encoded pulses", 32'(enc_cnt), 32'd1);

        // Floor 4 and cap 3.
        start_image(IMG_A, 1'b0, 8'd4, 4'd3);
        wait_idle("t2", 1000);
        repeat (3) tick();
        exp_q = '{6, 1, 2};
        check_order("t2");
        chk("t2 event_count", 32'(event_count), 32'd3);
        chk("t2 encoded pulses", 32'(enc_cnt), 32'd1);

        // Threshold mode at 5.
        start_image(IMG_A, 1'b1, 8'd5, 4'd0);
        wait_idle("t3", 1000);
        repeat (3) tick();
        exp_q = '{1, 2, 4, 6};
        check_order("t3");
        chk("t3 event_count", 32'(event_count), 32'd4);
        chk("t3 encoded pulses", 32'(enc_cnt), 32'd1);

        // All-zero image below the floor: nothing emitted.
        start_image('0, 1'b0, 8'd1, 4'd0);
        wait_idle("t4", 100);
        chk("t4 latency in range", 32'((last_wait >= N) && (last_wait <= N + 4)), 32'd1);
        repeat (3) tick();
        chk("t4 req count", 32'(addr_q.size()), 32'd0);
        chk("t4 event_count", 32'(event_count), 32'd0);
        chk("t4 encoded pulses", 32'(enc_cnt), 32'd1);

        // Slow receiver forces scan stalls.
        ack_delay = 20;
        start_image(IMG_A, 1'b0, 8'd0, 4'd0);
        wait_idle("t5", 3000);
        repeat (3) tick();
        exp_q = '{6, 1, 2, 4, 0, 5, 7, 3};
        check_order("t5");
        chk("t5 addr stable under req", 32'(unstable), 32'd0);
        chk("t5 event_count", 32'(event_count), 32'd8);
        chk("t5 encoded pulses", 32'(enc_cnt), 32'd1);

        // Abort while the first request is outstanding.
        start_image(IMG_A, 1'b0, 8'd0, 4'd0);
        begin
            int n = 0;
            while (!aer_req && n < 200) begin
                tick();
                n++;
            end
        end
        chk("t6 req seen", 32'(aer_req), 32'd1);
        inference_done = 1'b1;
        tick();
        inference_done = 1'b0;
        wait_idle("t6", 500);
        repeat (30) tick();
        chk("t6 req count", 32'(addr_q.size()), 32'd1);
        chk("t6 event_count", 32'(event_count), 32'd1);
        chk("t6 encoded pulses", 32'(enc_cnt), 32'd0);
        chk("t6 req low", 32'(aer_req), 32'd0);
        chk("t6 busy low", 32'(busy), 32'd0);

        // Restart with INFERENCE_DONE asserted on the start cycle.
        ack_delay = 1;
        image      = IMG_A;
        mode       = 1'b1;
        min_level  = 8'd5;
        max_events = 4'd0;
        addr_q.delete();
        enc_cnt    = 0;
        new_image      = 1'b1;
        inference_done = 1'b1;
        tick();
        new_image      = 1'b0;
        inference_done = 1'b0;
        chk("t7 start accepted", 32'(busy), 32'd1);
        wait_idle("t7", 1000);
        repeat (3) tick();
        exp_q = '{1, 2, 4, 6};
        check_order("t7");
        chk("t7 event_count", 32'(event_count), 32'd4);
        chk("t7 encoded pulses", 32'(enc_cnt), 32'd1);

        // Reset during the second request.
        ack_delay = 20;
        start_image(IMG_A, 1'b0, 8'd0, 4'd0);
        begin
            int n = 0;
            while (!(aer_req && event_count == 4'd1) && n < 500) begin
                tick();
                n++;
            end
        end
        chk("t8 second req", 32'(aer_req), 32'd1);
        chk("t8 second addr", 32'(aer_addr), 32'd1);
        rst = 1'b0;
        tick();
        chk("t8 busy", 32'(busy), 32'd0);
        chk("t8 req", 32'(aer_req), 32'd0);
        chk("t8 addr", 32'(aer_addr), 32'd0);
        chk("t8 count", 32'(event_count), 32'd0);
        chk("t8 enc", 32'(image_encoded), 32'd0);
        rst = 1'b1;
        addr_q.delete();
        repeat (40) tick();
        chk("t8 no pending events", 32'(addr_q.size()), 32'd0);

        // Clean run after the reset.
        ack_delay = 1;
        start_image(IMG_A, 1'b0, 8'd4, 4'd3);
        wait_idle("t9", 1000);
        repeat (3) tick();
        exp_q = '{6, 1, 2};
        check_order("t9");
        chk("t9 event_count", 32'(event_count), 32'd3);
        chk("t9 encoded pulses", 32'(enc_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
